// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receiver slice.
//   rx_state_e           : receiver FSM states
//   DATA_BITS            : payload bits per frame (fixed at 8)
//   CLKS_PER_BIT_DEFAULT : default oversampling ratio
//   PARITY_MODE          : parity sense used by the optional parity check
//   parity_of()          : expected parity bit for a payload byte
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 16;

    typedef enum logic {
        PAR_EVEN,
        PAR_ODD
    } parity_mode_e;

    localparam parity_mode_e PARITY_MODE = PAR_EVEN;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_MODE == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// ----------------------------------------------------------------------------
// uart_receiver_if
// Bundles the receiver's line input, enable and result/strobe outputs.
//   iEN        : receiver enable (low forces IDLE)
//   iRx        : asynchronous serial line, idle high
//   odata      : last good byte
//   oValid     : one-cycle strobe, odata updated
//   oParityErr : one-cycle strobe, parity mismatch
//   oFrameErr  : one-cycle strobe, stop bit sampled low
//   oBusy      : receiver not in IDLE
// Modports: slave = receiver side, master = line driver / consumer side.
// ----------------------------------------------------------------------------
interface uart_receiver_if;
    import uart_pkg::*;

    logic                 iEN;
    logic                 iRx;
    logic [DATA_BITS-1:0] odata;
    logic                 oValid;
    logic                 oParityErr;
    logic                 oFrameErr;
    logic                 oBusy;

    modport slave (
        input  iEN, iRx,
        output odata, oValid, oParityErr, oFrameErr, oBusy
    );

    modport master (
        output iEN, iRx,
        input  odata, oValid, oParityErr, oFrameErr, oBusy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the serial line plus one delayed copy used to
// detect a falling edge on the synchronized line.
//   iClk   : system clock
//   iRst_n : synchronous active-low reset (flops preset to 1)
//   iRx    : asynchronous serial input
//   oRx    : synchronized line (2 cycles of latency)
//   oFall  : synchronized line went 1 -> 0 this cycle
// ----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iRx,
    output logic oRx,
    output logic oFall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // NOTE: the flops reset to 1 (line idle), not 0, so leaving reset can
    // never look like a start-bit falling edge. Reset is sampled on the clock.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its source, forming a true shift chain.
            r_meta <= iRx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign oRx   = r_sync;
    assign oFall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_receiver.sv
// ----------------------------------------------------------------------------
// uart_receiver
// Serial-to-parallel UART receiver: 1 start bit, 8 data bits LSB first,
// optional even parity bit, 1 stop bit. Each bit is sampled at mid-bit.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state and makes
// oParityErr functional; otherwise oParityErr is tied low).
//   iClk   : system clock, rising edge
//   iRst_n : synchronous active-low reset
//   bus    : uart_receiver_if.slave (iEN, iRx in; odata, oValid,
//            oParityErr, oFrameErr, oBusy out)
// ----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic           iClk,
    input  logic           iRst_n,
    uart_receiver_if.slave bus
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W   = $clog2(DATA_BITS);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] TIMER_HALF = TIMER_W'(CLKS_PER_BIT / 2);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DATA_BITS - 1);

    rx_state_e            r_state,   w_state_nxt;
    logic [TIMER_W-1:0]   r_timer,   w_timer_nxt;
    logic [IDX_W-1:0]     r_bit_idx, w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
    logic [DATA_BITS-1:0] r_data,    w_data_nxt;
    logic                 r_valid,   w_valid_nxt;
    logic                 r_ferr,    w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_err, w_par_err_nxt;
    logic                 r_perr,    w_perr_nxt;
`endif

    logic w_rx;
    logic w_fall;
    logic w_tick;

    uart_rx_sync u_sync (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iRx    (bus.iRx),
        .oRx    (w_rx),
        .oFall  (w_fall)
    );

    // The timer wraps at CLKS_PER_BIT-1; loading it with half a bit on the
    // start edge puts every subsequent wrap at the middle of a bit.
    assign w_tick = (r_timer == TIMER_LAST);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_idx_nxt     = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_data_nxt    = r_data;
        w_valid_nxt   = 1'b0;
        w_ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_err_nxt = r_par_err;
        w_perr_nxt    = 1'b0;
`endif

        if (!bus.iEN) begin
            w_state_nxt = IDLE;
            w_timer_nxt = '0;
            w_idx_nxt   = '0;
        end else begin
            if (r_state != IDLE) begin
                w_timer_nxt = w_tick ? '0 : r_timer + TIMER_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        w_state_nxt = START;
                        w_timer_nxt = TIMER_HALF;
                    end
                end

                START: begin
                    if (w_tick) begin
                        // A line already back high at mid start bit is a glitch.
                        if (w_rx) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = DATA;
                            w_idx_nxt   = '0;
                        end
                    end
                end

                DATA: begin
                    if (w_tick) begin
                        w_shift_nxt[r_bit_idx] = w_rx;
                        if (r_bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = PARITY;
`else
                            w_state_nxt = STOP;
`endif
                        end else begin
                            w_idx_nxt = r_bit_idx + IDX_W'(1);
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        w_par_err_nxt = (w_rx != parity_of(r_shift));
                        w_state_nxt   = STOP;
                    end
                end
`endif

                STOP: begin
                    if (w_tick) begin
                        if (w_rx) begin
`ifdef UART_RX_PARITY_EN
                            if (r_par_err) begin
                                w_perr_nxt = 1'b1;
                            end else begin
                                w_valid_nxt = 1'b1;
                                w_data_nxt  = r_shift;
                            end
`else
                            w_valid_nxt = 1'b1;
                            w_data_nxt  = r_shift;
`endif
                        end else begin
                            w_ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                            w_perr_nxt = r_par_err;
`endif
                        end
                        // A start edge coinciding with the return to IDLE is
                        // taken immediately rather than lost.
                        if (w_fall) begin
                            w_state_nxt = START;
                            w_timer_nxt = TIMER_HALF;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_ferr    <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_err <= w_par_err_nxt;
            r_perr    <= w_perr_nxt;
`endif
        end
    end

    assign bus.odata     = r_data;
    assign bus.oValid    = r_valid;
    assign bus.oFrameErr = r_ferr;
    assign bus.oBusy     = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.oParityErr = r_perr;
`else
    assign bus.oParityErr = 1'b0;
`endif

endmodule
